mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multicycle RV32I control unit, the successor to the single-cycle controller. It is a Moore FSM that sequences fetch, decode, execute, memory and writeback over a shared datapath with one memory port and one ALU. It adds the full RV32I branch set, JALR, LUI/AUIPC, a variable-latency memory handshake and illegal-instruction trapping. It sits between the instruction register/flags and the multicycle datapath muxes and strobes.

Parameters:
ALUCTRL_W, 4, width of alu_control (4 is the minimum for the full RV32I ALU op set).
MEM_WAIT, 1, 1: honour mem_ready; 0: mem_ready ignored and treated as 1 (single-cycle memory).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory completes the current access this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
adr_src  out  1  0: PC, 1: ALUOut
ir_write  out  1  load IR and OldPC
pc_write  out  1  PC load enable
reg_write  out  1  register file write
result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result direct
alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J (combinational from opcode)
alu_control  out  ALUCTRL_W  ALU operation
illegal_instr  out  1  sticky trap flag
state_o  out  4  current state (debug)

Behaviour:
- State register: the only sequential element besides illegal_instr. All other outputs are Moore decodes of state, plus funct3/flags in BRANCH and EXECR/EXECI.
- Reset (rst_n low, async): state=FETCH, illegal_instr=0. While rst_n is low, mem_read, mem_write, ir_write, pc_write and reg_write are forced to 0. The first active FETCH is the first clk edge after rst_n rises.
- State codes (4 bits, also on state_o):
  - FETCH=0: adr_src=0, mem_read=1, A=PC, B=4, add, result_src=10. ir_write and pc_write are asserted only in the cycle where mem_ready=1. Stays in FETCH while mem_ready=0.
  - DECODE=1: A=OldPC, B=imm, add (branch/JAL target into ALUOut). Next state by opcode:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 or 0010111 -> UIMM
    - anything else -> TRAP
  - MEMADR=2: A=rs1, B=imm, add. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
  - MEMREAD=3: adr_src=1, mem_read=1. Advances to MEMWB on mem_ready.
  - MEMWB=4: result_src=01, reg_write=1. Next: FETCH.
  - MEMWRITE=5: adr_src=1, mem_write=1. Advances to FETCH on mem_ready.
  - EXECR=6: A=rs1, B=rs2, alu_op=10. Next: ALUWB.
  - EXECI=7: A=rs1, B=imm, alu_op=10. Next: ALUWB.
  - ALUWB=8: result_src=00, reg_write=1. Next: FETCH.
  - BRANCH=9: A=rs1, B=rs2, sub, result_src=00. pc_write=taken. Next: FETCH.
    - taken by funct3: 000 zero; 001 !zero; 100 lt; 101 !lt; 110 ltu; 111 !ltu.
    - funct3 010/011 -> TRAP, pc_write=0.
  - JAL=10: result_src=00, pc_write=1, A=OldPC, B=4, add (link value into ALUOut). Next: ALUWB.
  - JALR=11: A=rs1, B=imm (I-type), add. Target goes into ALUOut. Next: JAL, whose PC load and link then apply unchanged.
  - UIMM=12: A=11 (zero) if opcode[5]=1 (LUI), else A=01 (OldPC, AUIPC); B=imm (U-type), add. Next: ALUWB.
  - TRAP=13: illegal_instr=1, all strobes 0. Held until reset.
  - Codes 14/15: unreachable; if entered, go to TRAP.
- ALU decode (alu_op: 00 add, 01 sub, 10 by funct3/funct7_5):
  - funct7_5 selects SUB only when opcode[5]=1.
  - funct7_5 selects SRA for funct3=101 in both R and I forms.
- Latency in cycles with mem_ready always 1:
  - R/I-type, LUI/AUIPC: 4
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
  - Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds 1.
- Memory handshake: request strobes stay high and constant until mem_ready=1 is sampled. They never deassert early.
- Reset mid-access drops the request immediately (async) and discards the transfer.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - alu_op codes
  - ALU control encoding (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9)
  - imm_src, result_src and alu_src encodings
- One sub-module: alu_decoder, parametrised by ALUCTRL_W. Instantiated once inside mc_controller.
- FSM and output decode live in mc_controller.

Test Plan:
- add (0110011, f3=000, f7_5=0), mem_ready=1 -> states 0,1,6,8,0; alu_control=1 (SUB) not seen; reg_write only in cycle 4; ADD=0 in EXECR.
- lw with mem_ready low 2 cycles in MEMREAD -> mem_read held 3 cycles, adr_src=1; MEMWB at cycle 7; reg_write=1, result_src=01.
- beq, zero=1 -> pc_write=1 in BRANCH. bltu, ltu=0 -> pc_write=0. funct3=010 -> TRAP and illegal_instr=1.
- jalr -> states 0,1,11,10,8. pc_write=1 only in JAL; reg_write only in ALUWB.
- opcode 0000000 -> TRAP; illegal_instr stays 1 for 10 cycles; rst_n pulse clears it and returns to FETCH.
- rst_n low during MEMWRITE with mem_ready=0 -> mem_write drops the same cycle; state_o=0 after release.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: states, opcodes, ALU and mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_UIMM     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps alu_op plus funct3/funct7_5 onto the ALU operation code.
// Latency: combinational.
// Backpressure: none.
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           alu_op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALUCTRL_W'(ALU_ADD);
        case (alu_op)
            ALUOP_SUB: alu_control = ALUCTRL_W'(ALU_SUB);
            ALUOP_FUNCT: begin
                case (funct3)
                    // instr[30] is part of the immediate for ADDI, so only R-type may select SUB
                    3'b000: alu_control = (op5 && funct7_5) ? ALUCTRL_W'(ALU_SUB) : ALUCTRL_W'(ALU_ADD);
                    3'b001: alu_control = ALUCTRL_W'(ALU_SLL);
                    3'b010: alu_control = ALUCTRL_W'(ALU_SLT);
                    3'b011: alu_control = ALUCTRL_W'(ALU_SLTU);
                    3'b100: alu_control = ALUCTRL_W'(ALU_XOR);
                    3'b101: alu_control = funct7_5 ? ALUCTRL_W'(ALU_SRA) : ALUCTRL_W'(ALU_SRL);
                    3'b110: alu_control = ALUCTRL_W'(ALU_OR);
                    default: alu_control = ALUCTRL_W'(ALU_AND);
                endcase
            end
            default: alu_control = ALUCTRL_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over a shared datapath.
// Latency: 3..5 cycles per instruction, plus one per mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE.
// Backpressure: memory requests are held constant until mem_ready is sampled high; reset drops them at once.
module mc_controller
    import rv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter bit MEM_WAIT  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal_instr,
    output logic [3:0]           state_o
);

    state_t     state_q, state_d;
    logic       illegal_q;
    logic       rdy;
    logic       mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic [1:0] alu_op;

    assign rdy = MEM_WAIT ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        alu_op      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write_c = rdy;
                pc_write_c = rdy;
                if (rdy)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI, OP_AUIPC:  state_d = S_UIMM;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                mem_read_c = 1'b1;
                if (rdy)
                    state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_MEM;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (rdy)
                    state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_SUB;
                state_d   = S_FETCH;
                case (funct3)
                    3'b000:  pc_write_c = zero;
                    3'b001:  pc_write_c = ~zero;
                    3'b100:  pc_write_c = lt;
                    3'b101:  pc_write_c = ~lt;
                    3'b110:  pc_write_c = ltu;
                    3'b111:  pc_write_c = ~ltu;
                    default: state_d = S_TRAP;
                endcase
            end
            S_JAL: begin
                // PC takes the target already in ALUOut while the ALU forms the link value
                pc_write_c = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_d    = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_JAL;
            end
            S_UIMM: begin
                alu_src_a = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_d   = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_comb begin
        case (opcode)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            OP_JAL:           imm_src = IMM_J;
            default:          imm_src = IMM_I;
        endcase
    end

    alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .op5         (opcode[5]),
        .alu_control (alu_control)
    );

    // state resets asynchronously to FETCH, so strobes are gated to keep memory idle during reset
    assign mem_read      = mem_read_c  & rst_n;
    assign mem_write     = mem_write_c & rst_n;
    assign ir_write      = ir_write_c  & rst_n;
    assign pc_write      = pc_write_c  & rst_n;
    assign reg_write     = reg_write_c & rst_n;
    assign illegal_instr = illegal_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction expected cycle traces built from the instruction class,
// with random memory stalls and random instructions, checked by immediate assertions.
module tb_mc_controller;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       ltu = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic [3:0] state_o;

    int n_assert = 0;
    int n_fail   = 0;

    mc_controller #(.ALUCTRL_W(4), .MEM_WAIT(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .lt            (lt),
        .ltu           (ltu),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input logic op5);
        case (f3)
            3'd0:    return (op5 && f7) ? 4'd1 : 4'd0;
            3'd1:    return 4'd7;
            3'd2:    return 4'd5;
            3'd3:    return 4'd6;
            3'd4:    return 4'd4;
            3'd5:    return f7 ? 4'd9 : 4'd8;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return lu;
            3'd7:    return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] op);
        if (op == OP_STORE) return 3'd1;
        if (op == OP_BR) return 3'd2;
        if (op == OP_LUI || op == OP_AUIPC) return 3'd3;
        if (op == OP_JAL) return 3'd4;
        return 3'd0;
    endfunction

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_state", state_o, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_illegal", illegal_instr, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Expected state sequence per instruction class, expanded with stall cycles.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input logic l, input logic lu,
                             input int fwait, input int mwait, input bit abort);
        int   base[$];
        int   st[$];
        logic rq[$];
        logic tk;
        int   s, ea, eb, ec, er;
        tk = ref_taken(f3, z, l, lu);
        case (op)
            OP_LOAD:          base = {1, 2, 3, 4};
            OP_STORE:         base = {1, 2, 5};
            OP_R:             base = {1, 6, 8};
            OP_I:             base = {1, 7, 8};
            OP_BR:            if (f3 == 3'd2 || f3 == 3'd3) base = {1, 9, 13}; else base = {1, 9};
            OP_JAL:           base = {1, 10, 8};
            OP_JALR:          base = {1, 11, 10, 8};
            OP_LUI, OP_AUIPC: base = {1, 12, 8};
            default:          base = {1, 13};
        endcase
        for (int i = 0; i < fwait; i++) begin st.push_back(0); rq.push_back(1'b0); end
        st.push_back(0); rq.push_back(1'b1);
        foreach (base[k]) begin
            if (base[k] == 3 || base[k] == 5) begin
                for (int i = 0; i < mwait; i++) begin st.push_back(base[k]); rq.push_back(1'b0); end
                st.push_back(base[k]); rq.push_back(1'b1);
            end else begin
                st.push_back(base[k]); rq.push_back(1'($urandom));
            end
        end
        if (base[base.size()-1] == 13)
            for (int i = 0; i < 10; i++) begin st.push_back(13); rq.push_back(1'($urandom)); end

        foreach (st[c]) begin
            @(negedge clk);
            opcode = op; funct3 = f3; funct7_5 = f7; zero = z; lt = l; ltu = lu;
            mem_ready = rq[c];
            #1;
            s = st[c];
            chk("state", state_o, s);
            chk("mem_read", mem_read, (s == 0 || s == 3));
            chk("mem_write", mem_write, (s == 5));
            chk("ir_write", ir_write, (s == 0 && rq[c]));
            chk("pc_write", pc_write, ((s == 0 && rq[c]) || s == 10 || (s == 9 && tk)));
            chk("reg_write", reg_write, (s == 4 || s == 8));
            chk("illegal", illegal_instr, (s == 13));
            chk("imm_src", imm_src, ref_imm(op));
            if (s == 0 || s == 3 || s == 5) chk("adr_src", adr_src, (s != 0));
            ea = -1; eb = -1; ec = -1; er = -1;
            case (s)
                0:  begin ea = 0; eb = 2; ec = 0; er = 2; end
                1:  begin ea = 1; eb = 1; ec = 0; end
                2:  begin ea = 2; eb = 1; ec = 0; end
                4:  er = 1;
                6:  begin ea = 2; eb = 0; ec = int'(ref_alu(f3, f7, op[5])); end
                7:  begin ea = 2; eb = 1; ec = int'(ref_alu(f3, f7, op[5])); end
                8:  er = 0;
                9:  begin ea = 2; eb = 0; ec = 1; er = 0; end
                10: begin ea = 1; eb = 2; ec = 0; er = 0; end
                11: begin ea = 2; eb = 1; ec = 0; end
                12: begin ea = op[5] ? 3 : 1; eb = 1; ec = 0; end
                default: ;
            endcase
            if (ea >= 0) chk("alu_src_a", alu_src_a, ea);
            if (eb >= 0) chk("alu_src_b", alu_src_b, eb);
            if (ec >= 0) chk("alu_control", alu_control, ec);
            if (er >= 0) chk("result_src", result_src, er);
            if (abort && s == 5) begin
                do_reset();
                return;
            end
        end
        if (st[st.size()-1] == 13)
            do_reset();
    endtask

    initial begin
        logic [6:0] op;
        repeat (2) @(negedge clk);
        do_reset();
        run_instr(OP_R,   3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);  // add
        run_instr(OP_R,   3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);  // sub
        run_instr(OP_I,   3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);  // addi with instr[30] set
        run_instr(OP_I,   3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);  // srai
        run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0); // lw, 2 stall cycles
        run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0);
        run_instr(OP_BR,  3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);  // beq taken
        run_instr(OP_BR,  3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);  // bltu not taken
        run_instr(OP_BR,  3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);  // illegal branch funct3
        run_instr(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(OP_AUIPC, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0);
        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 3, 1'b1); // reset mid-write
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0: op = OP_LOAD;
                1: op = OP_STORE;
                2: op = OP_R;
                3: op = OP_I;
                4: op = OP_BR;
                5: op = OP_JAL;
                6: op = OP_JALR;
                7: op = OP_LUI;
                8: op = OP_AUIPC;
                default: op = 7'($urandom);
            endcase
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
